// File: rtl/hazard_fwd_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_fwd_ctrl_if
//   Bundles the pipeline-side view of the hazard/forwarding controller.
//   master : pipeline (drives register fields and stage flags, reads controls)
//   slave  : hazard_fwd_ctrl (reads register fields, drives controls)
//   Signals:
//     id_*          ID-stage source fields and usage flags
//     ex_* mem_* wb_* in-flight destinations and write enables
//     fwd_a_sel / fwd_b_sel  registered EX operand mux selects
//     stall_if / stall_id / flush_ex  pipeline hold and bubble controls
//     muldiv_busy   mult/div countdown active
//     stall_cycles  stall counter, present only with HAZARD_PERF_EN
// ---------------------------------------------------------------------------
interface hazard_fwd_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        id_uses_hilo;
  logic        id_muldiv_start;
  logic [4:0]  ex_rd;
  logic        ex_regwrite;
  logic        ex_memread;
  logic [4:0]  mem_rd;
  logic        mem_regwrite;
  logic [4:0]  wb_rd;
  logic        wb_regwrite;
  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  logic        stall_if;
  logic        stall_id;
  logic        flush_ex;
  logic        muldiv_busy;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles;
`endif

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_uses_hilo, id_muldiv_start,
    output ex_rd, ex_regwrite, ex_memread, mem_rd, mem_regwrite, wb_rd, wb_regwrite,
`ifdef HAZARD_PERF_EN
    input  stall_cycles,
`endif
    input  fwd_a_sel, fwd_b_sel, stall_if, stall_id, flush_ex, muldiv_busy
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_uses_hilo, id_muldiv_start,
    input  ex_rd, ex_regwrite, ex_memread, mem_rd, mem_regwrite, wb_rd, wb_regwrite,
`ifdef HAZARD_PERF_EN
    output stall_cycles,
`endif
    output fwd_a_sel, fwd_b_sel, stall_if, stall_id, flush_ex, muldiv_busy
  );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_fwd_ctrl
//   Hazard and forwarding controller for the 5-stage MIPS pipeline.
//   - Compares ID sources (rs/rt) against EX/MEM/WB destinations and registers
//     a 2-bit operand mux select per source, valid while the instruction is
//     in EX: 00 regfile, 01 EX/MEM ALU, 10 MEM/WB, 11 latched WB data.
//   - Detects load-use hazards (one bubble, tracked by a RUN/LOAD_STALL FSM).
//   - Counts down the multi-cycle mult/div unit and stalls HI/LO users and
//     new mult/div starts while it is busy.
//   Ports:
//     clk  system clock, rising edge
//     rst  asynchronous, active-high reset
//     bus  hazard_fwd_ctrl_if.slave (see interface header for signal list)
//   Parameter:
//     MD_LATENCY  cycles the mult/div unit is busy after a start (2..63)
//   Optional feature macro:
//     HAZARD_PERF_EN  adds bus.stall_cycles, a free-running count of
//                     stalled cycles (wraps at 2^32)
// ---------------------------------------------------------------------------
module hazard_fwd_ctrl #(
  parameter int MD_LATENCY = 32
) (
  input  logic              clk,
  input  logic              rst,
  hazard_fwd_ctrl_if.slave  bus
);

  if (MD_LATENCY < 2 || MD_LATENCY > 63) begin : g_bad_latency
    $error("hazard_fwd_ctrl: MD_LATENCY must be within 2..63");
  end

  localparam logic [5:0] MD_RELOAD = 6'(MD_LATENCY - 1);

  typedef enum logic {
    RUN        = 1'b0,
    LOAD_STALL = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  md_cnt_q, md_cnt_d;
  logic [1:0]  fwd_a_q, fwd_a_d;
  logic [1:0]  fwd_b_q, fwd_b_d;

  // Per-operand views: index 0 is rs (operand A), index 1 is rt (operand B).
  logic [4:0]  src      [2];
  logic        uses     [2];
  logic        live     [2];
  logic        hit_ex   [2];
  logic        hit_mem  [2];
  logic        hit_wb   [2];
  logic [1:0]  sel_raw  [2];

  assign src[0]  = bus.id_rs;
  assign src[1]  = bus.id_rt;
  assign uses[0] = bus.id_uses_rs;
  assign uses[1] = bus.id_uses_rt;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      // $0 is hardwired zero and an unused field is don't-care, so neither
      // may ever pick up a forwarded value.
      assign live[gi]    = uses[gi] && (src[gi] != 5'd0);
      assign hit_ex[gi]  = live[gi] && (src[gi] == bus.ex_rd);
      assign hit_mem[gi] = live[gi] && bus.mem_regwrite && (src[gi] == bus.mem_rd);
      assign hit_wb[gi]  = live[gi] && bus.wb_regwrite  && (src[gi] == bus.wb_rd);

      // Youngest producer wins.
      always_comb begin
        sel_raw[gi] = 2'b00;
        if (hit_ex[gi] && bus.ex_regwrite) begin
          sel_raw[gi] = 2'b01;
        end else if (hit_mem[gi]) begin
          sel_raw[gi] = 2'b10;
        end else if (hit_wb[gi]) begin
          sel_raw[gi] = 2'b11;
        end
      end
    end
  endgenerate

  logic load_use;
  logic md_busy;
  logic hilo_hazard;
  logic stall;

  // hit_ex already excludes $0, so ex_rd != 0 is implied by any hit.
  assign load_use    = bus.ex_memread && bus.ex_regwrite && (hit_ex[0] || hit_ex[1]);
  assign md_busy     = (md_cnt_q != 6'd0);
  assign hilo_hazard = (bus.id_uses_hilo || bus.id_muldiv_start) && md_busy;

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    fwd_a_d  = sel_raw[0];
    fwd_b_d  = sel_raw[1];
    md_cnt_d = md_cnt_q;

    // Stall outputs are combinational and must vanish the moment reset is
    // raised, not just at the next edge.
    stall = !rst && (load_use || hilo_hazard);

    case (state_q)
      RUN: begin
        if (load_use) begin
          state_d = LOAD_STALL;
        end
      end
      LOAD_STALL: begin
        // One cycle only; a fresh load-use seen here starts a new bubble.
        state_d = load_use ? LOAD_STALL : RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // A stalled instruction is replaced by a bubble in EX, so its operands
    // must not forward anything.
    if (stall) begin
      fwd_a_d = 2'b00;
      fwd_b_d = 2'b00;
    end

    // A start while busy is itself a stall, so it can never reload here.
    if (bus.id_muldiv_start && !stall) begin
      md_cnt_d = MD_RELOAD;
    end else if (md_busy) begin
      md_cnt_d = md_cnt_q - 6'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      md_cnt_q <= 6'd0;
      fwd_a_q  <= 2'b00;
      fwd_b_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
      fwd_a_q  <= fwd_a_d;
      fwd_b_q  <= fwd_b_d;
    end
  end

  assign bus.fwd_a_sel   = fwd_a_q;
  assign bus.fwd_b_sel   = fwd_b_q;
  assign bus.stall_if    = stall;
  assign bus.stall_id    = stall;
  assign bus.flush_ex    = stall;
  assign bus.muldiv_busy = md_busy;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= 32'd0;
    end else if (stall) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_cycles_q;
`endif

endmodule
